fifo_sync_fwft_ctrl: RTL and testbench
======================================

# fifo_sync_fwft_ctrl

Single-clock FIFO controller that drives the write and read ports of a distributed simple-dual-port RAM. The RAM is 2^ADDR_WIDTH x DATA_WIDTH, with a combinational read and no output register. The controller owns the write and read pointers, the full/empty and water-level flags, and a first-word-fall-through (FWFT) output register with a valid/ready handshake. It sits between a producer stream and a consumer stream inside the 32-in/32-out sync FIFO.

## Interface

- ADDR_WIDTH, 5: RAM address width, range 4-10. RAM depth D = 2^ADDR_WIDTH.
- DATA_WIDTH, 32: data width, range 1-256.
- ALMOST_FULL_NUM, 28: almost_full asserts when level >= this value; range 1..D.
- ALMOST_EMPTY_NUM, 4: almost_empty asserts when level <= this value; range 0..D.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  producer write request.
- wr_data  in  DATA_WIDTH  producer data.
- full  out  1  RAM holds D words; writes are refused.
- almost_full  out  1  level >= ALMOST_FULL_NUM.
- wr_err  out  1  one-cycle pulse: previous cycle had wr_en while full.
- rd_valid  out  1  rd_data holds a valid word.
- rd_ready  in  1  consumer accepts rd_data when rd_valid is high.
- rd_data  out  DATA_WIDTH  FWFT output register.
- almost_empty  out  1  level <= ALMOST_EMPTY_NUM.
- level  out  ADDR_WIDTH+1  words held: ram_count + rd_valid; range 0..D+1.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_WIDTH  RAM write address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_data  in  DATA_WIDTH  combinational RAM read data at ram_rd_addr.

## Operation

- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits are the RAM address; the MSB is the wrap bit.
- ram_count = wr_ptr - rd_ptr, computed modulo 2^(ADDR_WIDTH+1).
- full = (ram_count == D). ram_empty = (ram_count == 0).
- Write accept: wr_acc = wr_en & ~full.
  - ram_wr_en = wr_acc (combinational).
  - ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0]; ram_wr_data = wr_data.
  - wr_ptr increments on wr_acc.
- Read side: ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0], always.
- Output stage, two states:
  - EMPTY (rd_valid=0): if ~ram_empty, load rd_data <= ram_rd_data, rd_ptr++, go to VALID.
  - VALID (rd_valid=1), rd_ready=0: hold rd_data; stay in VALID.
  - VALID, rd_ready=1, ~ram_empty: load the next word, rd_ptr++, stay in VALID.
  - VALID, rd_ready=1, ram_empty: go to EMPTY; rd_data holds its last value.
- Total capacity is D+1 words (D in RAM plus 1 in the output register).
- Simultaneous write and load are allowed in any state. Each pointer moves independently.
- There is no bypass: a write into an empty FIFO still passes through the RAM.
- Write while full: the word is dropped, no pointer or RAM change, and wr_err pulses the next cycle.
- A read request without rd_valid is not an error and has no effect.
- Flags full, almost_full, almost_empty and level are decoded only from registered state (pointers, rd_valid). There is no combinational path from wr_en or rd_ready to any flag or to rd_valid.
- Reset, asynchronous at any time including mid-transfer: all state clears and any word in flight is discarded.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0.
  - rd_valid = 0, rd_data = 0.
  - full = 0, almost_full = 0, almost_empty = 1.
  - wr_err = 0, level = 0.
  - ram_wr_en = 0 (while wr_en is low).

## Timing

- Write-to-read latency is 2 cycles. A word written at edge N sits in RAM after N. It is loaded into rd_data at edge N+1, and rd_valid is high in the cycle after N+1.
- Sustained throughput is 1 word/clk in and 1 word/clk out once the FIFO is primed.
- full rises the cycle after the D-th RAM write. It falls the cycle after the first load that follows.
- Pointer wrap: pointer D-1 increments to D, which is address 0 with the wrap bit toggled. No glitch in full or empty across the wrap.

## Test plan

- Reset, then idle 5 cycles -> rd_valid=0, level=0, almost_empty=1, full=0, ram_wr_en=0.
- Single write 0xA5A5_0001 at edge N with rd_ready=0 -> rd_valid=1 and rd_data=0xA5A5_0001 from edge N+1. level is 1 after N, and stays 1 after N+1 (word has moved from RAM to the output register).
- 33 writes with rd_ready=0 (ADDR_WIDTH=5):
  - after write 28, level=28 and almost_full=1;
  - after write 33, full=1 and level=33;
  - a 34th write is dropped with wr_err=1 for one cycle.
- From full, rd_ready=1 and no writes -> 33 words out in order, one per cycle. rd_valid falls after the last word; almost_empty=1 at level<=4.
- Continuous wr_en and rd_ready=1 for 100 cycles of incrementing data -> no loss or duplication. level is steady at 2, the pointers wrap 3 times, and full is never asserted.
- Assert rst_n=0 mid-stream with level=10 -> all outputs take their reset values immediately. After release, the first new write appears 2 cycles later with none of the old data.

Source files
------------

// File: rtl/fifo_sync_fwft_ctrl.sv
// Single-clock FIFO controller for a distributed simple-dual-port RAM.
// It owns the pointers and flags, and holds the next word in a first-word-fall-through output register.
module fifo_sync_fwft_ctrl #(
  parameter int unsigned ADDR_WIDTH       = 5,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ALMOST_FULL_NUM  = 28,
  parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  wr_err,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  wr_err_q, wr_err_d;

  logic [PW-1:0] ram_count;
  logic          ram_empty;
  logic          wr_acc;
  logic          load;

  // Flags decode only registered state; the wrap bit keeps full and empty distinct.
  assign ram_count    = wr_ptr_q - rd_ptr_q;
  assign full         = (ram_count == PW'(DEPTH));
  assign ram_empty    = (ram_count == '0);
  assign rd_valid     = (state_q == ST_VALID);
  assign level        = ram_count + {{ADDR_WIDTH{1'b0}}, rd_valid};
  assign almost_full  = (level >= PW'(ALMOST_FULL_NUM));
  assign almost_empty = (level <= PW'(ALMOST_EMPTY_NUM));
  assign wr_err       = wr_err_q;
  assign rd_data      = rd_data_q;

  assign wr_acc      = wr_en & ~full;
  assign ram_wr_en   = wr_acc;
  assign ram_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_wr_data = wr_data;
  assign ram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

  // Load the output register when it is empty or being drained and the RAM has a word.
  assign load = ~ram_empty & (~rd_valid | rd_ready);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    wr_err_d  = wr_en & full;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (load) begin
      rd_data_d = ram_rd_data;
      rd_ptr_d  = rd_ptr_q + PW'(1);
    end
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_VALID;
      ST_VALID: if (rd_ready && ram_empty) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
      wr_err_q  <= wr_err_d;
    end
  end

endmodule

// File: tb/tb_fifo_sync_fwft_ctrl.sv
// Directed bench for fifo_sync_fwft_ctrl with a behavioural 32x32 RAM attached.
module tb_fifo_sync_fwft_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full, almost_full, wr_err, rd_valid, rd_ready, almost_empty;
  logic [31:0] rd_data;
  logic [5:0]  level;
  logic        ram_wr_en;
  logic [4:0]  ram_wr_addr, ram_rd_addr;
  logic [31:0] ram_wr_data, ram_rd_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = mem[ram_rd_addr];

  fifo_sync_fwft_ctrl #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .ALMOST_FULL_NUM(28), .ALMOST_EMPTY_NUM(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .almost_full(almost_full), .wr_err(wr_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .almost_empty(almost_empty), .level(level),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++; if (level !== 6'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got %b want 1", almost_empty); end
    checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b/%b want 0/0", full, almost_full); end
    checks++; if (ram_wr_en !== 1'b0 || wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr got %b/%b want 0/0", ram_wr_en, wr_err); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
  endtask

  task automatic test_single();
    wr_en = 1'b1; wr_data = 32'hA5A5_0001; rd_ready = 1'b0;
    #1;
    checks++; if (ram_wr_en !== 1'b1 || ram_wr_addr !== 5'd0) begin errors++; $display("FAIL single_ram_wr got %b@%0d want 1@0", ram_wr_en, ram_wr_addr); end
    tick();
    wr_en = 1'b0;
    checks++; if (rd_valid !== 1'b0 || level !== 6'd1) begin errors++; $display("FAIL single_edgeN got v=%b lvl=%0d want v=0 lvl=1", rd_valid, level); end
    tick();
    checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data got v=%b %h want v=1 a5a50001", rd_valid, rd_data); end
    checks++; if (level !== 6'd1) begin errors++; $display("FAIL single_level got %0d want 1", level); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0 || level !== 6'd0) begin errors++; $display("FAIL single_drain got v=%b lvl=%0d want v=0 lvl=0", rd_valid, level); end
  endtask

  task automatic test_fill();
    rd_ready = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      wr_en = 1'b1; wr_data = 32'h1000 + 32'(i);
      tick();
      checks++; if (level !== 6'(i)) begin errors++; $display("FAIL fill_level_%0d got %0d want %0d", i, level, i); end
      if (i == 27) begin
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL fill_af_27 got %b want 0", almost_full); end
      end
      if (i == 28) begin
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL fill_af_28 got %b want 1", almost_full); end
      end
      if (i == 32) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full_32 got %b want 0", full); end
      end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full_33 got %b want 1", full); end
    wr_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL fill_drop_ram_wr got %b want 0", ram_wr_en); end
    tick();
    wr_en = 1'b0;
    checks++; if (wr_err !== 1'b1 || level !== 6'd33) begin errors++; $display("FAIL fill_wr_err got e=%b lvl=%0d want e=1 lvl=33", wr_err, level); end
    tick();
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL fill_wr_err_clear got %b want 0", wr_err); end
  endtask

  task automatic test_drain();
    rd_ready = 1'b1;
    for (int k = 0; k < 33; k++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'h1000 + 32'(k + 1)) begin
        errors++; $display("FAIL drain_word_%0d got v=%b %h want v=1 %h", k, rd_valid, rd_data, 32'h1000 + 32'(k + 1));
      end
      checks++;
      if (level !== 6'(33 - k) || almost_empty !== ((33 - k) <= 4)) begin
        errors++; $display("FAIL drain_level_%0d got %0d ae=%b want %0d", k, level, almost_empty, 33 - k);
      end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0 || level !== 6'd0 || full !== 1'b0) begin errors++; $display("FAIL drain_end got v=%b lvl=%0d f=%b want 0/0/0", rd_valid, level, full); end
  endtask

  task automatic test_back_to_back();
    int exp_out = 0;
    int wraps = 0;
    int bad_level = 0;
    int saw_full = 0;
    rd_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_en = 1'b1; wr_data = 32'h5000_0000 + 32'(i);
      #1;
      if (i > 0 && ram_wr_addr == 5'd0 && ram_wr_en) wraps++;
      tick();
      if (full) saw_full++;
      if (i >= 1 && level !== 6'd2) bad_level++;
      if (rd_valid) begin
        checks++;
        if (rd_data !== 32'h5000_0000 + 32'(exp_out)) begin
          errors++; $display("FAIL stream_data_%0d got %h want %h", exp_out, rd_data, 32'h5000_0000 + 32'(exp_out));
        end
        exp_out++;
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 10 && rd_valid; i++) begin
      tick();
      if (rd_valid) begin
        checks++;
        if (rd_data !== 32'h5000_0000 + 32'(exp_out)) begin
          errors++; $display("FAIL stream_tail_%0d got %h want %h", exp_out, rd_data, 32'h5000_0000 + 32'(exp_out));
        end
        exp_out++;
      end
    end
    rd_ready = 1'b0;
    checks++; if (exp_out != 100 || rd_valid !== 1'b0) begin errors++; $display("FAIL stream_count got %0d v=%b want 100 v=0", exp_out, rd_valid); end
    checks++; if (wraps != 3) begin errors++; $display("FAIL stream_wraps got %0d want 3", wraps); end
    checks++; if (bad_level != 0) begin errors++; $display("FAIL stream_level got %0d bad cycles want 0", bad_level); end
    checks++; if (saw_full != 0) begin errors++; $display("FAIL stream_full got %0d cycles want 0", saw_full); end
  endtask

  task automatic test_reset_mid();
    rd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 32'h7700_0000 + 32'(i);
      tick();
    end
    checks++; if (level !== 6'd10) begin errors++; $display("FAIL mid_level got %0d want 10", level); end
    wr_data = 32'h7700_00FF;
    rst_n = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || level !== 6'd0 || rd_data !== 32'h0) begin errors++; $display("FAIL mid_reset got v=%b lvl=%0d %h want 0/0/0", rd_valid, level, rd_data); end
    checks++; if (almost_empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 || wr_err !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got ae=%b f=%b af=%b e=%b want 1/0/0/0", almost_empty, full, almost_full, wr_err); end
    wr_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 32'hBEEF_0001;
    tick();
    wr_en = 1'b0;
    checks++; if (rd_valid !== 1'b0 || level !== 6'd1) begin errors++; $display("FAIL post_reset_N got v=%b lvl=%0d want 0/1", rd_valid, level); end
    tick();
    checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hBEEF_0001) begin errors++; $display("FAIL post_reset_data got v=%b %h want 1 beef0001", rd_valid, rd_data); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0 || level !== 6'd0) begin errors++; $display("FAIL post_reset_no_old got v=%b lvl=%0d want 0/0", rd_valid, level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
